// File: rtl/sorter_pkg.sv
// Shared types and elaboration-time helpers for the pipelined bitonic sorter.
package sorter_pkg;

    // Compare-exchange partner of a lane within one network stage.
    typedef struct packed {
        logic [15:0] lane_b;
        logic        up;
    } pair_t;

    // Per-stage control that travels alongside the key vector.
    typedef struct packed {
        logic valid;
        logic desc;
    } stg_hdr_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

    function automatic int unsigned nstg(input int unsigned log2n);
        return log2n * (log2n + 1) / 2;
    endfunction

    // Stage s enumerates (block p, distance 2^q) with q counting down inside each block.
    function automatic pair_t partner(input int unsigned stage, input int unsigned lane,
                                      input int unsigned log2n);
        pair_t       r = '0;
        int unsigned k = 0;
        for (int unsigned p = 0; p < log2n; p++) begin
            for (int unsigned d = 0; d <= p; d++) begin
                if (k == stage) begin
                    r.lane_b = 16'(lane ^ (32'd1 << (p - d)));
                    r.up     = ((lane >> (p + 1)) & 32'd1) == 32'd0;
                end
                k++;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pipelined_bitonic_sorter_cmp_exchange.sv
// Single combinational compare-exchange cell: x_o takes the min when up_i, else the max.
module cmp_exchange #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         up_i,
    output logic [W-1:0] x_o,
    output logic [W-1:0] y_o
);

    logic swap_c;

    // Swap only on strict inequality so equal keys keep their lanes.
    always_comb begin
        swap_c = up_i ? (a_i > b_i) : (a_i < b_i);
        x_o    = swap_c ? b_i : a_i;
        y_o    = swap_c ? a_i : b_i;
    end

endmodule

// File: rtl/pipelined_bitonic_sorter.sv
// Fully registered N-key bitonic sorter with valid/ready, stall, flush and per-vector direction.
// Optional macro SORTER_INDEX_TAG_EN: keys carry their source lane, ties break by lane, out_idx added.
module pipelined_bitonic_sorter
    import sorter_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned N  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_desc,
    input  logic [DW*N-1:0]       in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW*N-1:0]       out_data
`ifdef SORTER_INDEX_TAG_EN
    ,
    output logic [clog2(N)*N-1:0] out_idx
`endif
);

    localparam int unsigned LOG2N = clog2(N);
    localparam int unsigned NSTG  = nstg(LOG2N);
`ifdef SORTER_INDEX_TAG_EN
    localparam int unsigned TW    = LOG2N;
`else
    localparam int unsigned TW    = 0;
`endif
    localparam int unsigned CW    = DW + TW;

    typedef logic [N-1:0][CW-1:0] vec_t;

    typedef struct packed {
        stg_hdr_t hdr;
        vec_t     elems;
    } stage_t;

    stage_t stg_q   [NSTG];
    stage_t stg_d   [NSTG];
    vec_t   net_out [NSTG];
    vec_t   in_vec_c;
    logic   adv_c;
    logic   accept_c;

    assign adv_c    = !stg_q[NSTG-1].hdr.valid || out_ready;
    assign in_ready = adv_c && !flush;
    assign accept_c = in_valid && in_ready;

    // Unpack the input lanes, appending the source lane as low-order tag when enabled.
    always_comb begin
        for (int i = 0; i < N; i++) begin
`ifdef SORTER_INDEX_TAG_EN
            in_vec_c[i] = {in_data[DW*i +: DW], TW'(i)};
`else
            in_vec_c[i] = in_data[DW*i +: DW];
`endif
        end
    end

    for (genvar K = 0; K < NSTG; K++) begin : g_stage
        vec_t cur;
        vec_t nxt;
        logic dsc;

        if (K == 0) begin : g_src_in
            assign cur = in_vec_c;
            assign dsc = in_desc;
        end else begin : g_src_reg
            assign cur = stg_q[K-1].elems;
            assign dsc = stg_q[K-1].hdr.desc;
        end

        for (genvar I = 0; I < N; I++) begin : g_lane
            localparam pair_t       PR = partner(K, I, LOG2N);
            localparam int unsigned LB = 32'(PR.lane_b);
            localparam logic        UP = PR.up;
            if (I < LB) begin : g_cell
                cmp_exchange #(.W(CW)) u_cx (
                    .a_i  (cur[I]),
                    .b_i  (cur[LB]),
                    .up_i (UP ^ dsc),
                    .x_o  (nxt[I]),
                    .y_o  (nxt[LB])
                );
            end
        end

        assign net_out[K] = nxt;
    end

    // Shared advance: every stage shifts together; flush clears all valids regardless of stall.
    always_comb begin
        for (int k = 0; k < NSTG; k++) stg_d[k] = stg_q[k];
        if (adv_c) begin
            stg_d[0].elems     = net_out[0];
            stg_d[0].hdr.valid = accept_c;
            stg_d[0].hdr.desc  = in_desc;
            for (int k = 1; k < NSTG; k++) begin
                stg_d[k].elems = net_out[k];
                stg_d[k].hdr   = stg_q[k-1].hdr;
            end
        end
        if (flush) begin
            for (int k = 0; k < NSTG; k++) stg_d[k].hdr.valid = 1'b0;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTG; k++) stg_q[k] <= '0;
        end else begin
            for (int k = 0; k < NSTG; k++) stg_q[k] <= stg_d[k];
        end
    end

    assign out_valid = stg_q[NSTG-1].hdr.valid;

    for (genvar J = 0; J < N; J++) begin : g_out
        assign out_data[DW*J +: DW] = stg_q[NSTG-1].elems[J][CW-1 -: DW];
`ifdef SORTER_INDEX_TAG_EN
        assign out_idx[LOG2N*J +: LOG2N] = stg_q[NSTG-1].elems[J][TW-1:0];
`endif
    end

endmodule

// File: tb/tb_pipelined_bitonic_sorter.sv
// Bench for pipelined_bitonic_sorter: N=4/DW=8 directed and stream tests, N=8 directed and random.
module tb_pipelined_bitonic_sorter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic flush;

    logic         a_in_valid, a_in_ready, a_in_desc, a_out_valid, a_out_ready;
    logic [31:0]  a_in_data, a_out_data;
    logic         b_in_valid, b_in_ready, b_in_desc, b_out_valid, b_out_ready;
    logic [31:0]  b_in_data, b_out_data;
    logic         c_in_valid, c_in_ready, c_in_desc, c_out_valid, c_out_ready;
    logic [7:0]   c_in_data, c_out_data;
    logic         d_in_valid, d_in_ready, d_in_desc, d_out_valid, d_out_ready;
    logic [127:0] d_in_data, d_out_data;
`ifdef SORTER_INDEX_TAG_EN
    logic [7:0]   a_out_idx;
    logic [23:0]  b_out_idx, c_out_idx, d_out_idx;
`endif

    int checks   = 0;
    int failures = 0;

    pipelined_bitonic_sorter #(.DW(8), .N(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_desc(a_in_desc), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
`ifdef SORTER_INDEX_TAG_EN
        , .out_idx(a_out_idx)
`endif
    );

    pipelined_bitonic_sorter #(.DW(4), .N(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_desc(b_in_desc), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
`ifdef SORTER_INDEX_TAG_EN
        , .out_idx(b_out_idx)
`endif
    );

    pipelined_bitonic_sorter #(.DW(1), .N(8)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_desc(c_in_desc), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data)
`ifdef SORTER_INDEX_TAG_EN
        , .out_idx(c_out_idx)
`endif
    );

    pipelined_bitonic_sorter #(.DW(16), .N(8)) u_dut_d (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_desc(d_in_desc), .in_data(d_in_data),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data)
`ifdef SORTER_INDEX_TAG_EN
        , .out_idx(d_out_idx)
`endif
    );

    // Reference: order lanes by (key, source lane) ascending, reverse the list for descending.
    function automatic void ref_sort(input int n, input int dw, input logic [127:0] din,
                                     input logic desc, output logic [127:0] dout,
                                     output logic [23:0] iout);
        int key [8];
        int lane[8];
        int lgn;
        int t;
        int src;
        lgn = (n == 8) ? 3 : 2;
        for (int i = 0; i < n; i++) begin
            key[i]  = int'((din >> (i * dw)) & ((128'd1 << dw) - 128'd1));
            lane[i] = i;
        end
        for (int i = 1; i < n; i++) begin
            for (int j = i; j > 0; j--) begin
                if (key[j-1] > key[j] || (key[j-1] == key[j] && lane[j-1] > lane[j])) begin
                    t = key[j-1];  key[j-1]  = key[j];  key[j]  = t;
                    t = lane[j-1]; lane[j-1] = lane[j]; lane[j] = t;
                end
            end
        end
        dout = '0;
        iout = '0;
        for (int j = 0; j < n; j++) begin
            src  = desc ? (n - 1 - j) : j;
            dout = dout | (128'(key[src]) << (j * dw));
            iout = iout | (24'(lane[src]) << (j * lgn));
        end
    endfunction

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0 || a_out_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_hold: valid=%b data=%h required valid=0 data=0", a_out_valid, a_out_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b a_valid=%b b_valid=%b required 1 0 0",
                     a_in_ready, a_out_valid, b_out_valid);
        end
`ifdef SORTER_INDEX_TAG_EN
        checks++;
        if (a_out_idx !== 8'h0) begin
            failures++;
            $display("FAIL reset_idx: got %h required 0", a_out_idx);
        end
`endif
    endtask

    // Sends {3,1,4,1} and checks the result appears exactly 3 cycles after acceptance.
    task automatic test_latency(input logic desc, input logic [31:0] exp);
        @(negedge clk);
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_desc   = desc;
        a_in_data   = {8'd1, 8'd4, 8'd1, 8'd3};
        #1;
        checks++;
        if (a_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL latency_ready: got %b required 1", a_in_ready);
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (c == 3) begin
                if (a_out_valid !== 1'b1 || a_out_data !== exp) begin
                    failures++;
                    $display("FAIL latency_out desc=%b: valid=%b data=%h required valid=1 data=%h",
                             desc, a_out_valid, a_out_data, exp);
                end
            end else if (a_out_valid !== 1'b0) begin
                failures++;
                $display("FAIL latency_idle cycle=%0d: valid=%b required 0", c, a_out_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0]  vin[8];
        logic [31:0]  exp[8];
        logic [127:0] e;
        logic [23:0]  ei;
        for (int i = 0; i < 8; i++) begin
            vin[i] = $urandom;
            ref_sort(4, 8, 128'(vin[i]), 1'(i % 2), e, ei);
            exp[i] = e[31:0];
        end
        a_out_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            a_in_valid = (cyc < 8);
            if (cyc < 8) begin
                a_in_data = vin[cyc];
                a_in_desc = 1'(cyc % 2);
            end
            #1;
            if (cyc < 8) begin
                checks++;
                if (a_in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_ready cyc=%0d: got %b required 1", cyc, a_in_ready);
                end
            end
            checks++;
            if (cyc >= 3 && cyc < 11) begin
                if (a_out_valid !== 1'b1 || a_out_data !== exp[cyc-3]) begin
                    failures++;
                    $display("FAIL b2b_out cyc=%0d: valid=%b data=%h required valid=1 data=%h",
                             cyc, a_out_valid, a_out_data, exp[cyc-3]);
                end
            end else if (a_out_valid !== 1'b0) begin
                failures++;
                $display("FAIL b2b_idle cyc=%0d: valid=%b required 0", cyc, a_out_valid);
            end
        end
        a_in_valid = 1'b0;
    endtask

    task automatic test_stall();
        logic [31:0]  vin[4];
        logic         vd[4];
        logic [31:0]  exp[4];
        logic [127:0] e;
        logic [23:0]  ei;
        int sent = 0;
        int recv = 0;
        int stall_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            vin[i] = $urandom;
            vd[i]  = 1'($urandom);
            ref_sort(4, 8, 128'(vin[i]), vd[i], e, ei);
            exp[i] = e[31:0];
        end
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            a_out_ready = (cyc >= 8);
            a_in_valid  = (sent < 4);
            if (sent < 4) begin
                a_in_data = vin[sent];
                a_in_desc = vd[sent];
            end
            #1;
            if (a_out_valid) begin
                checks++;
                if (recv >= 4) begin
                    failures++;
                    $display("FAIL stall_dup cyc=%0d: extra output %h required none", cyc, a_out_data);
                end else if (a_out_data !== exp[recv]) begin
                    failures++;
                    $display("FAIL stall_data cyc=%0d: got %h required %h", cyc, a_out_data, exp[recv]);
                end
                if (!a_out_ready) begin
                    stall_cnt++;
                    checks++;
                    if (a_in_ready !== 1'b0) begin
                        failures++;
                        $display("FAIL stall_in_ready cyc=%0d: got %b required 0", cyc, a_in_ready);
                    end
                end else begin
                    recv++;
                end
            end
            if (a_in_valid && a_in_ready) sent++;
        end
        a_in_valid = 1'b0;
        checks++;
        if (recv !== 4 || stall_cnt !== 5) begin
            failures++;
            $display("FAIL stall_count: received=%0d stalled=%0d required 4 and 5", recv, stall_cnt);
        end
    endtask

    task automatic test_flush();
        a_out_ready = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            a_in_valid = 1'b1;
            a_in_desc  = 1'($urandom);
            a_in_data  = $urandom;
        end
        @(negedge clk);
        flush     = 1'b1;
        a_in_data = $urandom;
        #1;
        checks++;
        if (a_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_in_ready: got %b required 0", a_in_ready);
        end
        @(negedge clk);
        flush      = 1'b0;
        a_in_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (a_out_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_drop cycle=%0d: valid=%b required 0", c, a_out_valid);
            end
            @(negedge clk);
        end
        test_latency(1'b0, {8'd4, 8'd3, 8'd1, 8'd1});
    endtask

    task automatic test_reset_mid();
        a_out_ready = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            a_in_valid = 1'b1;
            a_in_desc  = 1'($urandom);
            a_in_data  = $urandom;
        end
        #1;
        checks++;
        if (a_out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre: valid=%b required 1", a_out_valid);
        end
        rst_n      = 1'b0;
        a_in_valid = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_out_data !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_clear: valid=%b data=%h required 0 0", a_out_valid, a_out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
                failures++;
                $display("FAIL rstmid_after cycle=%0d: valid=%b in_ready=%b required 0 1",
                         c, a_out_valid, a_in_ready);
            end
        end
        test_latency(1'b1, {8'd1, 8'd1, 8'd3, 8'd4});
    endtask

    // N=8, DW=4 directed tie case: latency 6, lane-ordered ties.
    task automatic test_tag_directed(input logic desc, input logic [31:0] exp_d, input logic [23:0] exp_i);
        @(negedge clk);
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_desc   = desc;
        b_in_data   = {4'd15, 4'd0, 4'd2, 4'd5, 4'd15, 4'd0, 4'd5, 4'd5};
        @(negedge clk);
        b_in_valid = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            checks++;
            if (c == 6) begin
                if (b_out_valid !== 1'b1 || b_out_data !== exp_d) begin
                    failures++;
                    $display("FAIL tag_data desc=%b: valid=%b data=%h required valid=1 data=%h",
                             desc, b_out_valid, b_out_data, exp_d);
                end
`ifdef SORTER_INDEX_TAG_EN
                checks++;
                if (b_out_idx !== exp_i) begin
                    failures++;
                    $display("FAIL tag_idx desc=%b: got %h required %h", desc, b_out_idx, exp_i);
                end
`endif
            end else if (b_out_valid !== 1'b0) begin
                failures++;
                $display("FAIL tag_idle cycle=%0d: valid=%b required 0", c, b_out_valid);
            end
            @(negedge clk);
        end
        if (exp_i === 24'hx) $display("unreachable");
    endtask

    task automatic test_random_regression();
        logic [127:0] bq_d[$], cq_d[$], dq_d[$];
        logic [23:0]  bq_i[$], cq_i[$], dq_i[$];
        logic [127:0] e;
        logic [23:0]  ei;
        for (int cyc = 0; cyc < 90; cyc++) begin
            @(negedge clk);
            b_out_ready = (cyc >= 70) || (($urandom % 5) != 0);
            c_out_ready = (cyc >= 70) || (($urandom % 5) != 0);
            d_out_ready = (cyc >= 70) || (($urandom % 5) != 0);
            b_in_valid  = (cyc < 70) && (($urandom % 4) != 0);
            c_in_valid  = (cyc < 70) && (($urandom % 4) != 0);
            d_in_valid  = (cyc < 70) && (($urandom % 4) != 0);
            b_in_data   = $urandom;
            c_in_data   = 8'($urandom);
            d_in_data   = {$urandom, $urandom, $urandom, $urandom};
            b_in_desc   = 1'($urandom);
            c_in_desc   = 1'($urandom);
            d_in_desc   = 1'($urandom);
            #1;
            if (b_out_valid && b_out_ready) begin
                checks++;
                if (bq_d.size() == 0) begin
                    failures++;
                    $display("FAIL rand_b_spurious cyc=%0d: got %h required no output", cyc, b_out_data);
                end else begin
                    e  = bq_d.pop_front();
                    ei = bq_i.pop_front();
                    if (b_out_data !== e[31:0]) begin
                        failures++;
                        $display("FAIL rand_b_data cyc=%0d: got %h required %h", cyc, b_out_data, e[31:0]);
                    end
`ifdef SORTER_INDEX_TAG_EN
                    checks++;
                    if (b_out_idx !== ei) begin
                        failures++;
                        $display("FAIL rand_b_idx cyc=%0d: got %h required %h", cyc, b_out_idx, ei);
                    end
`endif
                end
            end
            if (c_out_valid && c_out_ready) begin
                checks++;
                if (cq_d.size() == 0) begin
                    failures++;
                    $display("FAIL rand_c_spurious cyc=%0d: got %h required no output", cyc, c_out_data);
                end else begin
                    e  = cq_d.pop_front();
                    ei = cq_i.pop_front();
                    if (c_out_data !== e[7:0]) begin
                        failures++;
                        $display("FAIL rand_c_data cyc=%0d: got %h required %h", cyc, c_out_data, e[7:0]);
                    end
`ifdef SORTER_INDEX_TAG_EN
                    checks++;
                    if (c_out_idx !== ei) begin
                        failures++;
                        $display("FAIL rand_c_idx cyc=%0d: got %h required %h", cyc, c_out_idx, ei);
                    end
`endif
                end
            end
            if (d_out_valid && d_out_ready) begin
                checks++;
                if (dq_d.size() == 0) begin
                    failures++;
                    $display("FAIL rand_d_spurious cyc=%0d: got %h required no output", cyc, d_out_data);
                end else begin
                    e  = dq_d.pop_front();
                    ei = dq_i.pop_front();
                    if (d_out_data !== e) begin
                        failures++;
                        $display("FAIL rand_d_data cyc=%0d: got %h required %h", cyc, d_out_data, e);
                    end
`ifdef SORTER_INDEX_TAG_EN
                    checks++;
                    if (d_out_idx !== ei) begin
                        failures++;
                        $display("FAIL rand_d_idx cyc=%0d: got %h required %h", cyc, d_out_idx, ei);
                    end
`endif
                end
            end
            if (b_in_valid && b_in_ready) begin
                ref_sort(8, 4, 128'(b_in_data), b_in_desc, e, ei);
                bq_d.push_back(e);
                bq_i.push_back(ei);
            end
            if (c_in_valid && c_in_ready) begin
                ref_sort(8, 1, 128'(c_in_data), c_in_desc, e, ei);
                cq_d.push_back(e);
                cq_i.push_back(ei);
            end
            if (d_in_valid && d_in_ready) begin
                ref_sort(8, 16, d_in_data, d_in_desc, e, ei);
                dq_d.push_back(e);
                dq_i.push_back(ei);
            end
        end
        checks++;
        if (bq_d.size() != 0 || cq_d.size() != 0 || dq_d.size() != 0) begin
            failures++;
            $display("FAIL rand_drain: pending b=%0d c=%0d d=%0d required 0 0 0",
                     bq_d.size(), cq_d.size(), dq_d.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        flush = 1'b0;
        a_in_valid = 1'b0; a_in_desc = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_desc = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        c_in_valid = 1'b0; c_in_desc = 1'b0; c_in_data = '0; c_out_ready = 1'b1;
        d_in_valid = 1'b0; d_in_desc = 1'b0; d_in_data = '0; d_out_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);

        test_reset();
        test_latency(1'b0, {8'd4, 8'd3, 8'd1, 8'd1});
        test_latency(1'b1, {8'd1, 8'd1, 8'd3, 8'd4});
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset_mid();
        test_tag_directed(1'b0, {4'd15, 4'd15, 4'd5, 4'd5, 4'd5, 4'd2, 4'd0, 4'd0},
                          {3'd7, 3'd3, 3'd4, 3'd1, 3'd0, 3'd5, 3'd6, 3'd2});
        test_tag_directed(1'b1, {4'd0, 4'd0, 4'd2, 4'd5, 4'd5, 4'd5, 4'd15, 4'd15},
                          {3'd2, 3'd6, 3'd5, 3'd0, 3'd1, 3'd4, 3'd3, 3'd7});
        test_random_regression();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
